spectro_column_scheduler: RTL and testbench

//  Sequences FFT output frames into the banked display RAM as spectrogram columns, between the
//  FFT/processing stage and bankRAM/coord_to_ram. Each frame becomes one column:
//  - per-bin magnitude, quantised to 4 bits
//  - written to a rotating column of a NO_FFTS-deep ring

---
 rtl/spectro_column_scheduler.sv | 150 +++++++++++++++
 tb/tb_spectro_column_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectro_column_scheduler.sv
// Writes each accepted FFT frame as one 4-bit-magnitude column of a rotating display-RAM ring.
// Latency: a bin accepted in cycle n is written in cycle n+1; drop pulse and pointer are registered.
// Backpressure: none, bins are never stalled; out-of-order or early frames are dropped and flagged.
module spectro_column_scheduler #(
    parameter int WORD_WIDTH    = 16,
    parameter int FFT_SIZE      = 128,
    parameter int NO_FFTS       = 50,
    parameter int NO_BANKS      = 2,
    parameter int ADDRESS_WIDTH = 12,
    parameter int MAG_SHIFT     = 8,
    parameter int DECIM         = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 bin_valid,
    input  logic [$clog2(FFT_SIZE/2)-1:0]        bin_idx,
    input  logic [2*WORD_WIDTH-1:0]              bin_data,
    input  logic                                 vsync,
    output logic [NO_BANKS-1:0]                  ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0]             ram_wr_address,
    output logic [3:0]                           ram_wr_data,
    output logic signed [$clog2(NO_FFTS):0]      oldest_fft_idx,
    output logic                                 frame_dropped,
    output logic                                 busy
);
    localparam int BINS  = FFT_SIZE / 2;
    localparam int IDX_W = $clog2(BINS);
    localparam int COL_W = $clog2(NO_FFTS);
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int MAG_W = WORD_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SKIP, S_COMMIT_WAIT} state_t;

    state_t                     state, state_nxt;
    logic [COL_W-1:0]           wr_col;
    logic [NO_BANKS-1:0]        bank;
    logic [ADDRESS_WIDTH-1:0]   col_base;
    logic [DEC_W-1:0]           decim_cnt;
    logic [IDX_W-1:0]           expected;

    logic                       frame_start, last_bin;
    logic                       wr_now, drop_now, commit_now, take_start;
    logic [COL_W-1:0]           wr_col_inc;
    logic                       wr_col_wrap;
    logic [NO_BANKS-1:0]        bank_rot;

    // Sign-extend by one bit so that |-2^(W-1)| is representable exactly.
    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [WORD_WIDTH-1:0] v);
        logic signed [MAG_W-1:0] e;
        e = {v[WORD_WIDTH-1], v};
        return e[MAG_W-1] ? -e : e;
    endfunction

    logic [MAG_W-1:0] mag, mag_shr;
    logic [3:0]       quant;

    assign mag     = abs_ext(bin_data[2*WORD_WIDTH-1:WORD_WIDTH]) + abs_ext(bin_data[WORD_WIDTH-1:0]);
    assign mag_shr = mag >> MAG_SHIFT;
    assign quant   = (mag_shr > MAG_W'(15)) ? 4'd15 : mag_shr[3:0];

    assign frame_start = bin_valid && (bin_idx == '0);
    assign last_bin    = (bin_idx == IDX_W'(BINS - 1));
    assign wr_col_wrap = (wr_col == COL_W'(NO_FFTS - 1));
    assign wr_col_inc  = wr_col_wrap ? '0 : wr_col + 1'b1;
    assign bank_rot    = (bank << 1) | (bank >> (NO_BANKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        wr_now     = 1'b0;
        drop_now   = 1'b0;
        commit_now = 1'b0;
        take_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    take_start = 1'b1;
                    if (decim_cnt == '0) begin
                        wr_now    = 1'b1;
                        state_nxt = S_CAPTURE;
                    end else begin
                        state_nxt = S_SKIP;
                    end
                end
            end
            S_CAPTURE: begin
                if (bin_valid) begin
                    if (bin_idx == expected) begin
                        wr_now = 1'b1;
                        if (last_bin) state_nxt = S_COMMIT_WAIT;
                    end else begin
                        drop_now  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_SKIP: begin
                if (bin_valid && last_bin) state_nxt = S_IDLE;
            end
            S_COMMIT_WAIT: begin
                // A frame arriving before the column is published has nowhere to go.
                if (frame_start) drop_now = 1'b1;
                if (vsync) begin
                    commit_now = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_CAPTURE) || (state == S_COMMIT_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_wr_en      <= '0;
            ram_wr_address <= '0;
            ram_wr_data    <= '0;
            oldest_fft_idx <= '0;
            frame_dropped  <= 1'b0;
            wr_col         <= '0;
            bank           <= NO_BANKS'(1);
            col_base       <= '0;
            decim_cnt      <= '0;
            expected       <= '0;
        end else begin
            ram_wr_en      <= wr_now ? bank : '0;
            ram_wr_address <= wr_now ? col_base + ADDRESS_WIDTH'(bin_idx) : '0;
            ram_wr_data    <= wr_now ? quant : '0;
            frame_dropped  <= drop_now;
            if (wr_now) expected <= bin_idx + 1'b1;
            if (take_start)
                decim_cnt <= (decim_cnt == DEC_W'(DECIM - 1)) ? '0 : decim_cnt + 1'b1;
            if (commit_now) begin
                wr_col         <= wr_col_inc;
                oldest_fft_idx <= {1'b0, wr_col_inc};
                bank           <= bank_rot;
                // Columns fill banks round-robin; the base advances once every bank has a column.
                if (wr_col_wrap)             col_base <= '0;
                else if (bank[NO_BANKS-1])   col_base <= col_base + ADDRESS_WIDTH'(BINS);
            end
        end
    end
endmodule

// File: tb/tb_spectro_column_scheduler.sv
// Randomised bench for spectro_column_scheduler: DECIM=1 and DECIM=3 instances share stimulus
// and are checked every cycle against a column-number-based reference model.
module tb_spectro_column_scheduler;
    localparam int W = 16, FFT_SIZE = 128, BINS = 64, NO_FFTS = 50, NO_BANKS = 2;
    localparam int AW = 12, MAG_SHIFT = 8;
    localparam int IW = $clog2(BINS), OW = $clog2(NO_FFTS) + 1;
    localparam int M_IDLE = 0, M_CAP = 1, M_SKIP = 2, M_WAIT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic bin_valid = 1'b0;
    logic [IW-1:0] bin_idx = '0;
    logic [2*W-1:0] bin_data = '0;
    logic vsync = 1'b0;

    logic [NO_BANKS-1:0] we_1, we_3;
    logic [AW-1:0] addr_1, addr_3;
    logic [3:0] data_1, data_3;
    logic signed [OW-1:0] oldest_1, oldest_3;
    logic drop_1, drop_3, busy_1, busy_3;

    always #5 clk = ~clk;

    spectro_column_scheduler #(.WORD_WIDTH(W), .FFT_SIZE(FFT_SIZE), .NO_FFTS(NO_FFTS),
        .NO_BANKS(NO_BANKS), .ADDRESS_WIDTH(AW), .MAG_SHIFT(MAG_SHIFT), .DECIM(1)) dut_1 (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_data(bin_data),
        .vsync(vsync), .ram_wr_en(we_1), .ram_wr_address(addr_1), .ram_wr_data(data_1),
        .oldest_fft_idx(oldest_1), .frame_dropped(drop_1), .busy(busy_1));

    spectro_column_scheduler #(.WORD_WIDTH(W), .FFT_SIZE(FFT_SIZE), .NO_FFTS(NO_FFTS),
        .NO_BANKS(NO_BANKS), .ADDRESS_WIDTH(AW), .MAG_SHIFT(MAG_SHIFT), .DECIM(3)) dut_3 (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_idx(bin_idx), .bin_data(bin_data),
        .vsync(vsync), .ram_wr_en(we_3), .ram_wr_address(addr_3), .ram_wr_data(data_3),
        .oldest_fft_idx(oldest_3), .frame_dropped(drop_3), .busy(busy_3));

    int n_cmp = 0, n_bad = 0;

    // Reference model: one entry per instance.
    int m_decim[2] = '{1, 3};
    int m_mode[2], m_col[2], m_oldest[2], m_next[2], m_starts[2];
    int e_we[2], e_addr[2], e_data[2], e_drop[2];

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_col[k] = 0; m_oldest[k] = 0; m_next[k] = 0; m_starts[k] = 0;
            e_we[k] = 0; e_addr[k] = 0; e_data[k] = 0; e_drop[k] = 0;
        end
    endtask

    task automatic model_write(input int k, input int idx, input int re, input int im);
        int q;
        q = (iabs(re) + iabs(im)) >> MAG_SHIFT;
        e_we[k]   = 1 << (m_col[k] % NO_BANKS);
        e_addr[k] = (m_col[k] / NO_BANKS) * BINS + idx;
        e_data[k] = (q > 15) ? 15 : q;
    endtask

    task automatic model_step(input int k, input bit v, input int idx, input int re,
                              input int im, input bit vs);
        bit fs;
        fs = v && (idx == 0);
        e_we[k] = 0; e_addr[k] = 0; e_data[k] = 0; e_drop[k] = 0;
        case (m_mode[k])
            M_IDLE: if (fs) begin
                if (m_starts[k] % m_decim[k] == 0) begin
                    model_write(k, idx, re, im);
                    m_mode[k] = M_CAP;
                    m_next[k] = 1;
                end else begin
                    m_mode[k] = M_SKIP;
                end
                m_starts[k]++;
            end
            M_CAP: if (v) begin
                if (idx == m_next[k]) begin
                    model_write(k, idx, re, im);
                    m_next[k]++;
                    if (idx == BINS - 1) m_mode[k] = M_WAIT;
                end else begin
                    e_drop[k] = 1;
                    m_mode[k] = M_IDLE;
                end
            end
            M_SKIP: if (v && idx == BINS - 1) m_mode[k] = M_IDLE;
            default: begin
                if (fs) e_drop[k] = 1;
                if (vs) begin
                    m_col[k]    = (m_col[k] + 1) % NO_FFTS;
                    m_oldest[k] = m_col[k];
                    m_mode[k]   = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_dut(input int k, input int we, input int addr, input int data,
                             input int old, input int drp, input int bsy);
        chk($sformatf("d%0d_wr_en", k), we, e_we[k]);
        if (e_we[k] != 0) begin
            chk($sformatf("d%0d_wr_address", k), addr, e_addr[k]);
            chk($sformatf("d%0d_wr_data", k), data, e_data[k]);
        end
        chk($sformatf("d%0d_frame_dropped", k), drp, e_drop[k]);
        chk($sformatf("d%0d_oldest_fft_idx", k), old, m_oldest[k]);
        chk($sformatf("d%0d_busy", k), bsy, int'(m_mode[k] == M_CAP || m_mode[k] == M_WAIT));
    endtask

    task automatic cycle(input bit v, input int idx, input int re, input int im, input bit vs);
        @(negedge clk);
        bin_valid = v;
        bin_idx   = IW'(idx);
        bin_data  = {16'(re), 16'(im)};
        vsync     = vs;
        for (int k = 0; k < 2; k++) model_step(k, v, idx, re, im, vs);
        @(posedge clk);
        #1;
        check_dut(0, int'(we_1), int'(addr_1), int'(data_1), int'(oldest_1), int'(drop_1), int'(busy_1));
        check_dut(1, int'(we_3), int'(addr_3), int'(data_3), int'(oldest_3), int'(drop_3), int'(busy_3));
    endtask

    task automatic gen(input int kind, input int b, output int re, output int im);
        logic signed [15:0] r;
        case (kind)
            1: begin re = 256; im = -256; end
            2: case (b % 3)
                   0: begin re = 32767;  im = 32767; end
                   1: begin re = -32768; im = 0;     end
                   default: begin re = 255; im = 0;  end
               endcase
            default: begin
                r  = 16'($urandom);
                re = int'(r >>> $urandom_range(0, 9));
                r  = 16'($urandom);
                im = int'(r >>> $urandom_range(0, 9));
            end
        endcase
    endtask

    task automatic idle_cycle();
        int re, im;
        gen(0, 0, re, im);
        cycle(1'b0, $urandom_range(0, BINS - 1), re, im, 1'b0);
    endtask

    task automatic send_bins(input int first, input int last, input int kind,
                             input int gap_pct, input int vs_pct);
        int re, im;
        for (int b = first; b <= last; b++) begin
            while ($urandom_range(0, 99) < gap_pct) idle_cycle();
            gen(kind, b, re, im);
            cycle(1'b1, b, re, im, $urandom_range(0, 99) < vs_pct);
        end
    endtask

    task automatic vsync_pulse();
        cycle(1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_wr_en_1", int'(we_1), 0);
        chk("rst_wr_address_1", int'(addr_1), 0);
        chk("rst_wr_data_1", int'(data_1), 0);
        chk("rst_oldest_1", int'(oldest_1), 0);
        chk("rst_dropped_1", int'(drop_1), 0);
        chk("rst_busy_1", int'(busy_1), 0);
        chk("rst_wr_en_3", int'(we_3), 0);
        chk("rst_busy_3", int'(busy_3), 0);
        model_reset();
        bin_valid = 1'b0;
        vsync     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int re, im, ev;
        model_reset();
        do_reset();

        // Constant-magnitude frame, then publish.
        cycle(1'b1, 0, 256, -256, 1'b0);
        chk("t1_wr_en", int'(we_1), 1);
        chk("t1_addr", int'(addr_1), 0);
        chk("t1_data", int'(data_1), 2);
        send_bins(1, BINS - 1, 1, 20, 0);
        repeat (3) idle_cycle();
        chk("t1_oldest_before_vsync", int'(oldest_1), 0);
        vsync_pulse();
        chk("t1_oldest_after_vsync", int'(oldest_1), 1);
        chk("t1_busy_after_vsync", int'(busy_1), 0);

        // Saturation patterns.
        send_bins(0, BINS - 1, 2, 10, 0);
        vsync_pulse();

        // Out-of-order bin drops the frame.
        send_bins(0, 9, 0, 10, 0);
        gen(0, 12, re, im);
        cycle(1'b1, 12, re, im, 1'b0);
        chk("t3_drop", int'(drop_1), 1);
        chk("t3_no_write", int'(we_1), 0);
        chk("t3_oldest", int'(oldest_1), 2);
        send_bins(13, BINS - 1, 0, 0, 0);
        send_bins(0, BINS - 1, 0, 10, 0);
        vsync_pulse();

        // Fill the ring up to the last column, then wrap.
        while (m_col[0] != NO_FFTS - 1) begin
            send_bins(0, BINS - 1, 0, 5, 0);
            vsync_pulse();
        end
        gen(0, 0, re, im);
        cycle(1'b1, 0, re, im, 1'b0);
        chk("t4_last_bank", int'(we_1), 2);
        chk("t4_last_addr", int'(addr_1), 1536);
        send_bins(1, BINS - 1, 0, 5, 0);
        vsync_pulse();
        chk("t4_wrap_oldest", int'(oldest_1), 0);
        gen(0, 0, re, im);
        cycle(1'b1, 0, re, im, 1'b0);
        chk("t4_wrap_bank", int'(we_1), 1);
        chk("t4_wrap_addr", int'(addr_1), 0);
        send_bins(1, BINS - 1, 0, 5, 0);
        vsync_pulse();

        // Decimation: six frames, each published.
        do_reset();
        repeat (6) begin
            send_bins(0, BINS - 1, 0, 10, 0);
            vsync_pulse();
        end
        chk("t5_oldest_decim1", int'(oldest_1), 6);
        chk("t5_oldest_decim3", int'(oldest_3), 2);

        // Commit-wait edge cases.
        send_bins(0, BINS - 1, 0, 10, 0);
        gen(0, 0, re, im);
        cycle(1'b1, 0, re, im, 1'b0);
        chk("t6_early_drop", int'(drop_1), 1);
        chk("t6_early_oldest", int'(oldest_1), 6);
        send_bins(1, BINS - 1, 0, 0, 0);
        vsync_pulse();
        send_bins(0, BINS - 1, 0, 10, 0);
        gen(0, 0, re, im);
        cycle(1'b1, 0, re, im, 1'b1);
        chk("t6_vsync_drop", int'(drop_1), 1);
        chk("t6_vsync_commit", int'(oldest_1), 8);
        send_bins(1, BINS - 1, 0, 0, 0);
        send_bins(0, 9, 0, 10, 0);
        do_reset();

        // Random soak.
        for (int i = 0; i < 300; i++) begin
            ev = $urandom_range(0, 99);
            if (ev < 40) begin
                send_bins(0, BINS - 1, 0, $urandom_range(0, 30), 3);
            end else if (ev < 55) begin
                int k2;
                k2 = $urandom_range(0, BINS - 3);
                send_bins(0, k2, 0, 10, 3);
                gen(0, 0, re, im);
                cycle(1'b1, (k2 + 2 + $urandom_range(0, BINS - 3)) % BINS, re, im, 1'b0);
            end else if (ev < 80) begin
                vsync_pulse();
            end else if (ev < 88) begin
                gen(0, 0, re, im);
                cycle(1'b1, $urandom_range(1, BINS - 1), re, im, $urandom_range(0, 3) == 0);
            end else if (ev < 98) begin
                repeat ($urandom_range(1, 5)) idle_cycle();
            end else begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
